// File: rtl/read_ex_mem_if.sv
// rtl/read_ex_mem_if.sv - data-memory request/response bus between the MEM stage and data memory
interface read_ex_mem_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;

   // MEM stage side: issues the request, receives completion and load data
   modport master (
      output dmem_req,
      output dmem_we,
      output dmem_addr,
      output dmem_wdata,
      input  dmem_ready,
      input  dmem_rdata
   );

   // Memory side
   modport slave (
      input  dmem_req,
      input  dmem_we,
      input  dmem_addr,
      input  dmem_wdata,
      output dmem_ready,
      output dmem_rdata
   );
endinterface

// File: rtl/read_ex_mem.sv
// rtl/read_ex_mem.sv - MEM pipeline stage: data-memory access with stall, timeout and MEM/WB register
module read_ex_mem #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               mem_valid,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [31:0]        data_in,
   input  logic [31:0]        mem_addr,
   input  logic [4:0]         rd_mem,
   read_ex_mem_if.master      dmem,
   output logic               stall,
   output logic [31:0]        wb_data,
   output logic [4:0]         rd_wb,
   output logic               wb_valid,
   output logic               mem_err
);

   // Counter only needs to reach TIMEOUT_CYCLES-1; a zero timeout leaves it free-running and unused.
   localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic [CW-1:0]  wait_cnt;
   logic [4:0]     rd_lat;
   logic           is_mem_op;
   logic           timeout_hit;

   // Decode of the incoming entry and the timeout condition in the current access
   always_comb begin
      is_mem_op   = mem_valid & (mem_read | mem_write);
      timeout_hit = (TIMEOUT_CYCLES != 0) && (state == ACCESS) &&
                    (wait_cnt == LAST) && !dmem.dmem_ready;
   end

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and upstream stall; stall drops on the completing cycle so the next entry advances
   always_comb begin
      state_nx = state;
      stall    = 1'b0;
      case (state)
         IDLE: begin
            if (is_mem_op) begin
               stall    = 1'b1;
               state_nx = ACCESS;
            end
         end
         ACCESS: begin
            stall = !dmem.dmem_ready && !timeout_hit;
            if (dmem.dmem_ready || timeout_hit) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (!reset) begin
         stall = 1'b0;
      end
   end

   // Request latches, wait counter and MEM/WB register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dmem.dmem_req   <= 1'b0;
         dmem.dmem_we    <= 1'b0;
         dmem.dmem_addr  <= '0;
         dmem.dmem_wdata <= '0;
         rd_lat          <= '0;
         wait_cnt        <= '0;
         wb_data         <= '0;
         rd_wb           <= '0;
         wb_valid        <= 1'b0;
         mem_err         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (is_mem_op) begin
                  // Both read and write set counts as a store.
                  dmem.dmem_addr  <= mem_addr;
                  dmem.dmem_wdata <= data_in;
                  dmem.dmem_we    <= mem_write;
                  dmem.dmem_req   <= 1'b1;
                  rd_lat          <= rd_mem;
                  wait_cnt        <= '0;
                  wb_valid        <= 1'b0;
               end else if (mem_valid) begin
                  // Non-memory op passes the ALU result straight through, even for rd=0.
                  wb_data  <= mem_addr;
                  rd_wb    <= rd_mem;
                  wb_valid <= 1'b1;
               end else begin
                  wb_valid <= 1'b0;
               end
            end
            ACCESS: begin
               if (dmem.dmem_ready) begin
                  dmem.dmem_req <= 1'b0;
                  if (dmem.dmem_we) begin
                     wb_valid <= 1'b0;
                     rd_wb    <= '0;
                  end else begin
                     wb_data  <= dmem.dmem_rdata;
                     rd_wb    <= rd_lat;
                     wb_valid <= (rd_lat != 5'd0);
                  end
               end else if (timeout_hit) begin
                  // Abandon the entry; the error flag stays set until reset.
                  dmem.dmem_req <= 1'b0;
                  wb_valid      <= 1'b0;
                  mem_err       <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_read_ex_mem.sv
// tb/tb_read_ex_mem.sv - self-checking bench for read_ex_mem against a transaction-level model
module tb_read_ex_mem;
   localparam int T = 15;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        mem_valid, mem_read, mem_write;
   logic [31:0] data_in, mem_addr;
   logic [4:0]  rd_mem;
   logic        stall, wb_valid, mem_err;
   logic [31:0] wb_data;
   logic [4:0]  rd_wb;

   read_ex_mem_if dif();

   read_ex_mem #(.TIMEOUT_CYCLES(T)) dut (
      .clock     (clock),
      .reset     (reset),
      .mem_valid (mem_valid),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .data_in   (data_in),
      .mem_addr  (mem_addr),
      .rd_mem    (rd_mem),
      .dmem      (dif),
      .stall     (stall),
      .wb_data   (wb_data),
      .rd_wb     (rd_wb),
      .wb_valid  (wb_valid),
      .mem_err   (mem_err)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   // Model: one outstanding memory transaction plus the visible register values
   bit          m_pend, m_store;
   logic [4:0]  m_rd;
   int          m_waited;
   logic        m_req, m_we, m_wbv, m_err;
   logic [31:0] m_addr, m_wdata, m_wbd;
   logic [4:0]  m_rdwb;

   bit          last_st;
   logic        last_obs;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_store = 0; m_rd = '0; m_waited = 0;
      m_req = 0; m_we = 0; m_wbv = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_wbd = '0; m_rdwb = '0;
   endtask

   function automatic bit model_gives_up(input logic ready);
      return m_pend && !ready && (T != 0) && (m_waited == T - 1);
   endfunction

   function automatic bit model_stall(input logic v, input logic r, input logic w, input logic ready);
      if (!m_pend) return v && (r || w);
      return !ready && !model_gives_up(ready);
   endfunction

   task automatic model_edge(input logic v, input logic r, input logic w,
                             input logic [31:0] din, input logic [31:0] addr,
                             input logic [4:0] rdm, input logic ready, input logic [31:0] rdata);
      if (!m_pend) begin
         if (v && (r || w)) begin
            m_pend = 1; m_store = w; m_rd = rdm; m_waited = 0;
            m_addr = addr; m_wdata = din; m_we = w; m_req = 1; m_wbv = 0;
         end else if (v) begin
            m_wbd = addr; m_rdwb = rdm; m_wbv = 1;
         end else begin
            m_wbv = 0;
         end
      end else if (ready) begin
         m_pend = 0; m_req = 0;
         if (m_store) begin
            m_wbv = 0; m_rdwb = '0;
         end else begin
            m_wbd = rdata; m_rdwb = m_rd; m_wbv = (m_rd != 0);
         end
      end else if (model_gives_up(ready)) begin
         m_pend = 0; m_req = 0; m_wbv = 0; m_err = 1;
      end else begin
         m_waited++;
      end
   endtask

   task automatic check_outputs();
      chk("dmem_req",   dif.dmem_req,   m_req);
      chk("dmem_we",    dif.dmem_we,    m_we);
      chk("dmem_addr",  dif.dmem_addr,  m_addr);
      chk("dmem_wdata", dif.dmem_wdata, m_wdata);
      chk("wb_data",    wb_data,        m_wbd);
      chk("rd_wb",      rd_wb,          m_rdwb);
      chk("wb_valid",   wb_valid,       m_wbv);
      chk("mem_err",    mem_err,        m_err);
   endtask

   // One clock: drive after the falling edge, check stall, step the model at the rising edge, check registers
   task automatic cycle(input logic v, input logic r, input logic w,
                        input logic [31:0] din, input logic [31:0] addr,
                        input logic [4:0] rdm, input logic ready, input logic [31:0] rdata);
      mem_valid = v; mem_read = r; mem_write = w;
      data_in = din; mem_addr = addr; rd_mem = rdm;
      dif.dmem_ready = ready; dif.dmem_rdata = rdata;
      #1;
      last_st  = model_stall(v, r, w, ready);
      last_obs = stall;
      chk("stall", stall, last_st);
      @(posedge clock);
      model_edge(v, r, w, din, addr, rdm, ready, rdata);
      @(negedge clock);
      check_outputs();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic        cv, cr, cw;
   logic [31:0] cdin, caddr;
   logic [4:0]  crd;
   int          lat;
   int          stall_cnt;
   bit          was_pend;

   task automatic new_entry();
      int kind;
      kind  = $urandom_range(0, 3);
      cv    = ($urandom_range(0, 9) != 0);
      cr    = (kind == 1) || (kind == 3);
      cw    = (kind == 2) || (kind == 3);
      cdin  = $urandom;
      caddr = $urandom;
      crd   = 5'($urandom_range(0, 31));
   endtask

   initial begin
      mem_valid = 1; mem_read = 1; mem_write = 0;
      data_in = 32'h1111_1111; mem_addr = 32'h2222_2222; rd_mem = 5'd3;
      dif.dmem_ready = 1'b1; dif.dmem_rdata = 32'h3333_3333;
      reset = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_stall",      stall,          0);
      chk("rst_dmem_req",   dif.dmem_req,   0);
      chk("rst_dmem_we",    dif.dmem_we,    0);
      chk("rst_dmem_addr",  dif.dmem_addr,  0);
      chk("rst_dmem_wdata", dif.dmem_wdata, 0);
      chk("rst_wb_data",    wb_data,        0);
      chk("rst_rd_wb",      rd_wb,          0);
      chk("rst_wb_valid",   wb_valid,       0);
      chk("rst_mem_err",    mem_err,        0);
      model_reset();
      reset = 1'b1;

      // ALU op passes through in one edge, never stalls
      cycle(1, 0, 0, 32'h0, 32'h0000_1234, 5'd5, 0, 32'h0);
      chk("alu_stall",    last_obs, 0);
      chk("alu_wb_data",  wb_data,  32'h1234);
      chk("alu_rd_wb",    rd_wb,    5);
      chk("alu_wb_valid", wb_valid, 1);

      // Load with three wait cycles
      stall_cnt = 0;
      cycle(1, 1, 0, 32'h0, 32'h100, 5'd7, 0, 32'h0);
      stall_cnt += int'(last_obs);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 1, 0, 32'h0, 32'h100, 5'd7, 0, 32'h0);
         stall_cnt += int'(last_obs);
         chk("ld_addr_stable", dif.dmem_addr, 32'h100);
         chk("ld_req_held",    dif.dmem_req,  1);
      end
      cycle(1, 1, 0, 32'h0, 32'h100, 5'd7, 1, 32'hDEAD_BEEF);
      stall_cnt += int'(last_obs);
      chk("ld_stall_cycles", stall_cnt, 4);
      chk("ld_wb_data",      wb_data,   32'hDEAD_BEEF);
      chk("ld_rd_wb",        rd_wb,     7);
      chk("ld_wb_valid",     wb_valid,  1);

      // Store completing in the first access cycle, then an rd=0 ALU op right behind it
      cycle(1, 0, 1, 32'hA5A5_A5A5, 32'h200, 5'd9, 0, 32'h0);
      chk("st_we",    dif.dmem_we,    1);
      chk("st_wdata", dif.dmem_wdata, 32'hA5A5_A5A5);
      chk("st_req",   dif.dmem_req,   1);
      cycle(1, 0, 1, 32'hA5A5_A5A5, 32'h200, 5'd9, 1, 32'h0);
      chk("st_release", last_obs, 0);
      chk("st_wb_valid", wb_valid, 0);
      chk("st_req_drop", dif.dmem_req, 0);
      cycle(1, 0, 0, 32'h0, 32'h55, 5'd0, 0, 32'h0);
      chk("rd0_wb_valid", wb_valid, 1);
      chk("rd0_wb_data",  wb_data,  32'h55);

      // Back-to-back load then ALU op
      cycle(1, 1, 0, 32'h0, 32'h300, 5'd4, 0, 32'h0);
      cycle(1, 1, 0, 32'h0, 32'h300, 5'd4, 1, 32'hCAFE_0001);
      chk("b2b_ld_data", wb_data, 32'hCAFE_0001);
      chk("b2b_ld_v",    wb_valid, 1);
      cycle(1, 0, 0, 32'h0, 32'h77, 5'd6, 1, 32'h0);
      chk("b2b_alu_data", wb_data, 32'h77);
      chk("b2b_alu_rd",   rd_wb,   6);
      chk("b2b_no_dup",   dif.dmem_req, 0);

      // Load that never completes
      cycle(1, 1, 0, 32'h0, 32'h400, 5'd3, 0, 32'h0);
      stall_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         cycle(1, 1, 0, 32'h0, 32'h400, 5'd3, 0, 32'h0);
         stall_cnt += int'(last_obs);
      end
      chk("to_stall_cycles", stall_cnt, 14);
      chk("to_req",          dif.dmem_req, 0);
      chk("to_err",          mem_err, 1);
      chk("to_wb_valid",     wb_valid, 0);
      cycle(0, 0, 0, 32'h0, 32'h0, 5'd0, 1, 32'h0);
      cycle(1, 0, 0, 32'h0, 32'h9, 5'd2, 0, 32'h0);
      chk("err_sticky", mem_err, 1);

      // Reset in the middle of an access
      cycle(1, 1, 0, 32'h0, 32'h500, 5'd2, 0, 32'h0);
      cycle(1, 1, 0, 32'h0, 32'h500, 5'd2, 0, 32'h0);
      chk("pre_rst_req", dif.dmem_req, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_req",      dif.dmem_req,  0);
      chk("arst_addr",     dif.dmem_addr, 0);
      chk("arst_wb_data",  wb_data,       0);
      chk("arst_wb_valid", wb_valid,      0);
      chk("arst_err",      mem_err,       0);
      chk("arst_stall",    stall,         0);
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      cycle(1, 0, 0, 32'h0, 32'h99, 5'd1, 0, 32'h0);
      chk("post_rst_alu", wb_data, 32'h99);

      // Random traffic; upstream advances only when no stall is expected
      new_entry();
      lat = 0;
      for (int n = 0; n < 3000; n++) begin
         logic rdy;
         rdy = m_pend ? (m_waited == lat) : 1'($urandom_range(0, 1));
         was_pend = m_pend;
         cycle(cv, cr, cw, cdin, caddr, crd, rdy, $urandom);
         if (!last_st) new_entry();
         if (!was_pend && m_pend)
            lat = ($urandom_range(0, 7) == 0) ? 40 : $urandom_range(0, 4);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/read_ex_mem.md
READ_EX_MEM -- requirements
Module: read_ex_mem

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 15, max ACCESS-state cycles awaiting dmem_ready; 0 disables the timeout.
REQ-002 clock  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low; asserting it clears all state immediately, independent of clock.
REQ-004 mem_valid  in  1  EX/MEM entry valid.
REQ-005 mem_read  in  1  entry is a load.
REQ-006 mem_write  in  1  entry is a store.
REQ-007 data_in  in  32  store data from EX/MEM.
REQ-008 mem_addr  in  32  memory address, or ALU result for non-memory ops.
REQ-009 rd_mem  in  5  destination register.
REQ-010 dmem_req  out  1  data-memory request, registered.
REQ-011 dmem_we  out  1  1 = write, 0 = read.
REQ-012 dmem_addr  out  32  latched address.
REQ-013 dmem_wdata  out  32  latched store data.
REQ-014 dmem_ready  in  1  memory accepts/completes the request this cycle.
REQ-015 dmem_rdata  in  32  load data, valid when dmem_ready=1.
REQ-016 stall  out  1  combinational; holds the EX/MEM register upstream.
REQ-017 wb_data  out  32  MEM/WB result.
REQ-018 rd_wb  out  5  MEM/WB destination.
REQ-019 wb_valid  out  1  MEM/WB entry valid.
REQ-020 mem_err  out  1  sticky timeout flag.

Function
REQ-021 FSM states SHALL be IDLE and ACCESS only.
REQ-022 IDLE, mem_valid=1, mem_read=0, mem_write=0: next edge wb_data<=mem_addr, rd_wb<=rd_mem, wb_valid<=1; stall=0.
REQ-023 IDLE, mem_valid=0: next edge wb_valid<=0; wb_data and rd_wb hold.
REQ-024 IDLE, mem_valid=1 and (mem_read or mem_write): stall=1 this cycle; next edge latch dmem_addr<=mem_addr, dmem_wdata<=data_in, dmem_we<=mem_write, rd<=rd_mem; dmem_req<=1; wb_valid<=0; go to ACCESS.
REQ-025 mem_read and mem_write both 1 SHALL be treated as a store.
REQ-026 ACCESS: dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL remain stable until the edge at which dmem_ready=1 is sampled.
REQ-027 ACCESS: stall = NOT dmem_ready AND NOT timeout-hit, so the upstream register advances on the completing edge.
REQ-028 ACCESS with dmem_ready=1, load: next edge wb_data<=dmem_rdata, rd_wb<=latched rd, wb_valid<=(latched rd != 0), dmem_req<=0; go to IDLE.
REQ-029 ACCESS with dmem_ready=1, store: next edge wb_valid<=0, rd_wb<=0, dmem_req<=0; go to IDLE.
REQ-030 Minimum load latency: entry sampled at edge E0 yields wb_valid at edge E1 if dmem_ready=1 in the first ACCESS cycle.
REQ-031 Wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle without dmem_ready; timeout-hit = (count = TIMEOUT_CYCLES-1) AND NOT dmem_ready, with TIMEOUT_CYCLES != 0.
REQ-032 On timeout-hit: next edge dmem_req<=0, wb_valid<=0, mem_err<=1; go to IDLE; the entry is dropped.
REQ-033 dmem_ready while in IDLE SHALL be ignored.
REQ-034 A non-memory entry with rd_mem=0 SHALL still produce wb_valid=1.

Reset
REQ-035 While reset=0: state=IDLE, counter=0, and all outputs (dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_data, rd_wb, wb_valid, mem_err) = 0; stall=0.
REQ-036 Reset asserted mid-ACCESS SHALL drop dmem_req asynchronously and discard the pending access.
REQ-037 mem_err SHALL clear only by reset.

Verification
REQ-038 ALU op mem_valid=1, mem_addr=0x0000_1234, rd_mem=5 -> next edge wb_data=0x1234, rd_wb=5, wb_valid=1, stall never high.
REQ-039 Load addr=0x100, rd=7, dmem_ready after 3 ACCESS cycles with rdata=0xDEADBEEF -> stall high 4 cycles, dmem_addr stable, wb_data=0xDEADBEEF, rd_wb=7, wb_valid=1.
REQ-040 Store addr=0x200, data_in=0xA5A5A5A5, ready in first ACCESS cycle -> dmem_we=1, dmem_wdata=0xA5A5A5A5, wb_valid=0, next entry accepted the following cycle.
REQ-041 Load, dmem_ready never asserted, TIMEOUT_CYCLES=15 -> dmem_req drops after 15 ACCESS cycles, mem_err=1, stall releases, wb_valid=0.
REQ-042 Reset pulled low during ACCESS -> dmem_req=0 before next clock edge, all outputs 0, state IDLE.
REQ-043 Back-to-back load then ALU op -> ALU result appears exactly one edge after load's wb_valid, no duplicate load issued.
